// File: rtl/interp_pkg.sv
// -----------------------------------------------------------------------------
// interp_pkg
// Shared definitions for the interpolation front end (zero_stuff_upsamp and
// its FIFO). Holds the default sample width and interpolation ratio, the
// default signed sample type and a helper that sizes the phase counter.
// -----------------------------------------------------------------------------
package interp_pkg;

  localparam int DATA_WIDTH_DEF = 5;
  localparam int UP_FACTOR_DEF  = 4;

  typedef logic signed [DATA_WIDTH_DEF-1:0] sample_t;

  // Number of bits needed to count phases 0..l-1.
  function automatic int phase_width(input int l);
    return $clog2(l);
  endfunction

endpackage

// File: rtl/sample_fifo2.sv
// -----------------------------------------------------------------------------
// sample_fifo2
// Two-deep registered FIFO for signed samples. A written sample becomes
// visible on dout only from the following cycle on (no write-through).
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset, empties the FIFO
//   push  - write din this edge (ignored when full without a pop)
//   pop   - drop the head entry this edge (ignored when empty)
//   din   - sample to write
//   dout  - current head entry
//   count - number of stored entries (0..2)
// -----------------------------------------------------------------------------
module sample_fifo2
  import interp_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic signed [DATA_WIDTH-1:0] din,
  output logic signed [DATA_WIDTH-1:0] dout,
  output logic [1:0]                   count
);

  // slot0 is always the head; slot1 the younger entry.
  logic signed [DATA_WIDTH-1:0] slot0_q, slot0_d;
  logic signed [DATA_WIDTH-1:0] slot1_q, slot1_d;
  logic [1:0]                   count_q, count_d;

  // Next-state: shift on pop, append on push, both at once keeps order.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          slot0_d = din;
          count_d = 2'd1;
        end else if (count_q == 2'd1) begin
          slot1_d = din;
          count_d = 2'd2;
        end else begin
          count_d = count_q;
        end
      end
      2'b01: begin
        if (count_q != 2'd0) begin
          slot0_d = slot1_q;
          count_d = count_q - 2'd1;
        end else begin
          count_d = count_q;
        end
      end
      2'b11: begin
        if (count_q == 2'd2) begin
          slot0_d = slot1_q;
          slot1_d = din;
        end else begin
          // One entry leaves, the new one becomes head; an empty FIFO has
          // nothing to pop so this is a plain push.
          slot0_d = din;
          count_d = 2'd1;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot0_q <= {DATA_WIDTH{1'b0}};
      slot1_q <= {DATA_WIDTH{1'b0}};
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign dout  = slot0_q;
  assign count = count_q;

endmodule

// File: rtl/zero_stuff_upsamp.sv
// -----------------------------------------------------------------------------
// zero_stuff_upsamp
// Rate-L upsampler feeding the interpolation FIR. Low-rate samples arrive on
// a valid/ready handshake into a 2-entry buffer; a free-running phase counter
// pops one sample on each phase-0 slot and emits it, followed by UP_FACTOR-1
// zeros. A phase-0 slot that finds the buffer empty emits a zero and sets the
// sticky underflow flag. Samples pass bit-exact (no gain compensation).
//
// Optional build macro UPSAMP_HOLD_EN: zero-order hold instead of zero
// stuffing (non-sample slots and underflow slots repeat the previous output).
//
// Ports:
//   clk       - clock
//   rst       - synchronous active-high reset
//   in        - signed low-rate sample
//   in_valid  - in carries a sample
//   in_ready  - a sample is accepted this cycle if in_valid is high
//   out       - signed full-rate stream (registered)
//   out_first - out carries a phase-0 slot (registered)
//   underflow - sticky, a phase-0 slot found the buffer empty
// -----------------------------------------------------------------------------
module zero_stuff_upsamp
  import interp_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int UP_FACTOR  = UP_FACTOR_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] in,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic signed [DATA_WIDTH-1:0] out,
  output logic                         out_first,
  output logic                         underflow
);

  localparam int PW = phase_width(UP_FACTOR);
  localparam logic [PW-1:0] PHASE_LAST = PW'(UP_FACTOR - 1);

  logic [PW-1:0]                phase_q, phase_d;
  logic signed [DATA_WIDTH-1:0] out_q, out_d;
  logic                         first_q, first_d;
  logic                         uflow_q, uflow_d;

  logic                         phase0_s;
  logic                         push_s;
  logic                         pop_s;
  logic signed [DATA_WIDTH-1:0] head_s;
  logic [1:0]                   count_s;

  assign phase0_s = (phase_q == {PW{1'b0}});
  assign pop_s    = phase0_s && (count_s != 2'd0);
  // Full buffer may still accept on phase 0 because the pop frees a slot.
  assign in_ready = !rst && ((count_s < 2'd2) || phase0_s);
  assign push_s   = in_valid && in_ready;

  sample_fifo2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (in),
    .dout  (head_s),
    .count (count_s)
  );

  // Phase advance and output slot selection.
  always_comb begin
    phase_d = (phase_q == PHASE_LAST) ? {PW{1'b0}} : phase_q + {{(PW-1){1'b0}}, 1'b1};
    out_d   = out_q;
    first_d = 1'b0;
    uflow_d = uflow_q;
    if (phase0_s) begin
      first_d = 1'b1;
      if (count_s != 2'd0) begin
        out_d = head_s;
      end else begin
        uflow_d = 1'b1;
`ifdef UPSAMP_HOLD_EN
        out_d = out_q;
`else
        out_d = {DATA_WIDTH{1'b0}};
`endif
      end
    end else begin
      first_d = 1'b0;
`ifdef UPSAMP_HOLD_EN
      out_d = out_q;
`else
      out_d = {DATA_WIDTH{1'b0}};
`endif
    end
  end

  // Registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= {PW{1'b0}};
      out_q   <= {DATA_WIDTH{1'b0}};
      first_q <= 1'b0;
      uflow_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      out_q   <= out_d;
      first_q <= first_d;
      uflow_q <= uflow_d;
    end
  end

  assign out       = out_q;
  assign out_first = first_q;
  assign underflow = uflow_q;

endmodule

// File: tb/tb_zero_stuff_upsamp.sv
// -----------------------------------------------------------------------------
// tb_zero_stuff_upsamp
// Directed and random stimulus against a queue-based reference model of the
// upsampler: samples wait in a FIFO queue, a cycle count modulo L gives the
// slot, and each phase-0 slot takes the oldest sample that was accepted at
// an earlier edge.
// -----------------------------------------------------------------------------
module tb_zero_stuff_upsamp;
  import interp_pkg::*;

  localparam int DW = 5;
  localparam int L  = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [DW-1:0] in_s;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] out_s;
  logic                 out_first;
  logic                 underflow;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic signed [DW-1:0] m_q[$];
  int                   m_t = 0;
  logic signed [DW-1:0] m_out = '0;
  bit                   m_first = 1'b0;
  bit                   m_uf = 1'b0;
  bit                   m_acc = 1'b0;

  // Stimulus source for held-valid streams.
  logic signed [DW-1:0] src_q[$];

  always #5 clk = ~clk;

  zero_stuff_upsamp #(
    .DATA_WIDTH (DW),
    .UP_FACTOR  (L)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in_s),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out_s),
    .out_first (out_first),
    .underflow (underflow)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0t observed=%0d expected=%0d", tag, $time, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check in_ready, advance model, check outputs.
  task automatic step(input bit r, input bit v, input logic signed [DW-1:0] d);
    bit rdy;
    rst      = r;
    in_valid = v;
    in_s     = d;
    #1;
    rdy = !r && (m_q.size() < 2 || (m_t % L) == 0);
    check("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_t     = 0;
      m_out   = '0;
      m_first = 1'b0;
      m_uf    = 1'b0;
      m_acc   = 1'b0;
    end else begin
      m_acc = v && rdy;
      if ((m_t % L) == 0) begin
        m_first = 1'b1;
        if (m_q.size() > 0) begin
          m_out = m_q.pop_front();
        end else begin
          m_uf = 1'b1;
`ifndef UPSAMP_HOLD_EN
          m_out = '0;
`endif
        end
      end else begin
        m_first = 1'b0;
`ifndef UPSAMP_HOLD_EN
        m_out = '0;
`endif
      end
      if (m_acc) m_q.push_back(d);
      m_t++;
    end
    @(negedge clk);
    check("out", out_s, m_out);
    check("out_first", {31'd0, out_first}, {31'd0, m_first});
    check("underflow", {31'd0, underflow}, {31'd0, m_uf});
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, '0);
  endtask

  // Hold in_valid with the head of src_q until accepted, for at most budget cycles.
  task automatic feed_held(input int budget);
    int guard = 0;
    while (src_q.size() > 0 && guard < budget) begin
      step(1'b0, 1'b1, src_q[0]);
      if (m_acc) src_q.delete(0);
      guard++;
    end
  endtask

  initial begin
    logic signed [DW-1:0] rd;
    bit rr, rv;

    // Reset, then idle: zeros, out_first every L cycles, underflow sets.
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    idle(12);

    // Held-valid stream 3,5,7,-2.
    step(1'b1, 1'b0, '0);
    src_q.push_back(5'sd3);
    src_q.push_back(5'sd5);
    src_q.push_back(5'sd7);
    src_q.push_back(-5'sd2);
    feed_held(40);
    idle(8);

    // Extreme values with the buffer kept full.
    step(1'b1, 1'b0, '0);
    src_q.push_back(-5'sd16);
    src_q.push_back(5'sd15);
    src_q.push_back(-5'sd16);
    src_q.push_back(5'sd15);
    src_q.push_back(5'sd1);
    feed_held(60);
    idle(8);

    // Fill buffer, reset mid-operation, then 9 must be the first nonzero.
    step(1'b0, 1'b1, 5'sd1);
    step(1'b0, 1'b1, 5'sd2);
    step(1'b0, 1'b1, 5'sd3);
    step(1'b1, 1'b1, 5'sd4);
    idle(2);
    src_q.push_back(5'sd9);
    feed_held(20);
    idle(6);

    // Stop input after sample 4: next phase-0 slot underflows, flag sticks.
    src_q.push_back(5'sd4);
    feed_held(20);
    idle(12);

    // Samples 6 then 2 followed by starvation (zero-order hold case).
    step(1'b1, 1'b0, '0);
    src_q.push_back(5'sd6);
    src_q.push_back(5'sd2);
    feed_held(20);
    idle(12);

    // Random traffic with occasional resets.
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 300; i++) begin
      rr = ($urandom_range(0, 49) == 0);
      rv = ($urandom_range(0, 3) != 0);
      rd = DW'($urandom_range(0, 31));
      step(rr, rv, rd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
